// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix multiplier job sequencer.
package matmul_pkg;

    localparam int DATA_W  = 8;
    localparam int RES_W   = 20;
    localparam int DIM_W   = 2;
    localparam int MAX_DIM = 4;
    localparam int CNT_W   = $clog2(MAX_DIM * MAX_DIM) + 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN
    } state_t;

    // Number of C elements for a job, from the minus-one encoded dims (1..16).
    function automatic logic [CNT_W-1:0] job_total(input logic [DIM_W-1:0] a_rows,
                                                   input logic [DIM_W-1:0] b_cols);
        logic [CNT_W-1:0] r;
        logic [CNT_W-1:0] c;
        r = CNT_W'(a_rows) + CNT_W'(1);
        c = CNT_W'(b_cols) + CNT_W'(1);
        return r * c;
    endfunction

endpackage

// File: rtl/matmul_res_fifo.sv
// Small synchronous result FIFO; entries are {last, data}.
module matmul_res_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Job sequencer for the 4x4 signed matrix multiplier core: loads A then B,
// strobes one result per C element and returns results on a backpressured stream.
module matmul_sequencer #(
    parameter int DATA_W    = matmul_pkg::DATA_W,
    parameter int RES_W     = matmul_pkg::RES_W,
    parameter int OUT_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [matmul_pkg::DIM_W-1:0] cfg_a_rows,
    input  logic [matmul_pkg::DIM_W-1:0] cfg_a_cols,
    input  logic [matmul_pkg::DIM_W-1:0] cfg_b_rows,
    input  logic [matmul_pkg::DIM_W-1:0] cfg_b_cols,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [RES_W-1:0]             m_data,
    output logic                         m_last,
    output logic                         err,
    output logic                         busy,
    output logic                         core_rst,
    output logic [DATA_W-1:0]            core_in_data,
    output logic                         core_next_matrix,
    output logic                         core_can_read,
    output logic                         core_can_cao,
    output logic [matmul_pkg::DIM_W-1:0] core_row_counter,
    output logic [matmul_pkg::DIM_W-1:0] core_col_counter,
    input  logic [RES_W-1:0]             core_out_data
);
    import matmul_pkg::*;

    localparam int CW = $clog2(OUT_DEPTH) + 1;

    state_t           state, state_d;
    logic [DIM_W-1:0] a_rows, a_cols, b_rows, b_cols;
    logic [DIM_W-1:0] a_rows_d, a_cols_d, b_rows_d, b_cols_d;
    logic [DIM_W-1:0] row, col, row_d, col_d;
    logic [DIM_W-1:0] lim_row, lim_col;
    logic [CNT_W-1:0] issued, issued_d, total;

    logic              err_d, core_rst_d, can_read_d, next_matrix_d;
    logic [DATA_W-1:0] in_data_d;
    logic [DIM_W-1:0]  row_out_d, col_out_d;

    // [0] = strobe on the core this cycle, [1] = result to capture this cycle.
    logic [1:0] cao_pipe, last_pipe;
    logic       cao_d, cao_last_d;

    logic           beat, credit_ok;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [RES_W:0] fifo_head;

    assign cfg_ready    = (state == IDLE);
    assign s_ready      = (state == LOAD_A) || (state == LOAD_B);
    assign busy         = (state != IDLE);
    assign beat         = s_valid && s_ready;
    assign core_can_cao = cao_pipe[0];
    assign total        = job_total(a_rows, b_cols);
    assign lim_row      = (state == LOAD_B) ? b_rows : a_rows;
    assign lim_col      = (state == LOAD_B) ? b_cols : a_cols;

    // Credits count every result already queued or still in the core pipe.
    assign credit_ok = (int'(fifo_count) + int'(cao_pipe[0]) + int'(cao_pipe[1])) < OUT_DEPTH;

    always_comb begin
        state_d       = state;
        a_rows_d      = a_rows;
        a_cols_d      = a_cols;
        b_rows_d      = b_rows;
        b_cols_d      = b_cols;
        row_d         = row;
        col_d         = col;
        issued_d      = issued;
        err_d         = 1'b0;
        core_rst_d    = 1'b0;
        can_read_d    = 1'b0;
        next_matrix_d = core_next_matrix;
        in_data_d     = core_in_data;
        row_out_d     = core_row_counter;
        col_out_d     = core_col_counter;
        cao_d         = 1'b0;
        cao_last_d    = 1'b0;

        case (state)
            INIT: begin
                if (!core_rst)
                    core_rst_d = 1'b1;
                else
                    state_d = IDLE;
            end
            IDLE: begin
                if (cfg_valid) begin
                    a_rows_d = cfg_a_rows;
                    a_cols_d = cfg_a_cols;
                    b_rows_d = cfg_b_rows;
                    b_cols_d = cfg_b_cols;
                    if (cfg_a_cols != cfg_b_rows) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD_A;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                if (beat) begin
                    can_read_d    = 1'b1;
                    in_data_d     = s_data;
                    next_matrix_d = (state == LOAD_B);
                    row_out_d     = row;
                    col_out_d     = col;
                    if (col == lim_col) begin
                        col_d = '0;
                        if (row == lim_row) begin
                            row_d    = '0;
                            issued_d = '0;
                            state_d  = (state == LOAD_A) ? LOAD_B : COMPUTE;
                        end else begin
                            row_d = row + DIM_W'(1);
                        end
                    end else begin
                        col_d = col + DIM_W'(1);
                    end
                end
            end
            COMPUTE: begin
                // Strobe is registered, so it lands at least one cycle after the last write.
                if (credit_ok) begin
                    cao_d    = 1'b1;
                    issued_d = issued + CNT_W'(1);
                    if (issued + CNT_W'(1) == total) begin
                        cao_last_d = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cao_pipe == 2'b00 && fifo_empty)
                    state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= INIT;
            a_rows           <= '0;
            a_cols           <= '0;
            b_rows           <= '0;
            b_cols           <= '0;
            row              <= '0;
            col              <= '0;
            issued           <= '0;
            err              <= 1'b0;
            core_rst         <= 1'b0;
            core_can_read    <= 1'b0;
            core_next_matrix <= 1'b0;
            core_in_data     <= '0;
            core_row_counter <= '0;
            core_col_counter <= '0;
            cao_pipe         <= '0;
            last_pipe        <= '0;
        end else begin
            state            <= state_d;
            a_rows           <= a_rows_d;
            a_cols           <= a_cols_d;
            b_rows           <= b_rows_d;
            b_cols           <= b_cols_d;
            row              <= row_d;
            col              <= col_d;
            issued           <= issued_d;
            err              <= err_d;
            core_rst         <= core_rst_d;
            core_can_read    <= can_read_d;
            core_next_matrix <= next_matrix_d;
            core_in_data     <= in_data_d;
            core_row_counter <= row_out_d;
            core_col_counter <= col_out_d;
            cao_pipe         <= {cao_pipe[0], cao_d};
            last_pipe        <= {last_pipe[0], cao_last_d};
        end
    end

    matmul_res_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (RES_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cao_pipe[1]),
        .push_data ({last_pipe[1], core_out_data}),
        .pop       (m_ready),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_head[RES_W-1:0];
    assign m_last  = m_valid && fifo_head[RES_W];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: behavioural core model, reference C = A x B
// per job pushed to a scoreboard, and an independent result monitor.
module tb_matmul_sequencer;
    localparam int DATA_W    = 8;
    localparam int RES_W     = 20;
    localparam int OUT_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_a_rows = '0, cfg_a_cols = '0, cfg_b_rows = '0, cfg_b_cols = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [RES_W-1:0]  m_data;
    logic              m_last;
    logic              err;
    logic              busy;
    logic              core_rst;
    logic [DATA_W-1:0] core_in_data;
    logic              core_next_matrix;
    logic              core_can_read;
    logic              core_can_cao;
    logic [1:0]        core_row_counter;
    logic [1:0]        core_col_counter;
    logic [RES_W-1:0]  core_out_data = '0;

    matmul_sequencer #(
        .DATA_W(DATA_W), .RES_W(RES_W), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_a_rows(cfg_a_rows), .cfg_a_cols(cfg_a_cols),
        .cfg_b_rows(cfg_b_rows), .cfg_b_cols(cfg_b_cols),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .err(err), .busy(busy),
        .core_rst(core_rst), .core_in_data(core_in_data),
        .core_next_matrix(core_next_matrix), .core_can_read(core_can_read),
        .core_can_cao(core_can_cao), .core_row_counter(core_row_counter),
        .core_col_counter(core_col_counter), .core_out_data(core_out_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [20:0] exp_q[$];
    int ja[4][4];
    int jb[4][4];
    int rdy_mode = 0;
    int rdy_phase = 0;
    int rd_cnt = 0, cao_cnt = 0, both_cnt = 0, err_cnt = 0, ovf_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core model: stores written elements, returns one C element per strobe.
    logic signed [7:0] cm_a[4][4];
    logic signed [7:0] cm_b[4][4];
    int cm_ar = 0, cm_ac = 0, cm_bc = 0, cm_pr = 0, cm_pc = 0;

    always @(posedge clk) begin
        int s;
        if (core_rst) begin
            cm_pr <= 0;
            cm_pc <= 0;
        end
        if (core_can_read && !core_next_matrix) begin
            cm_a[core_row_counter][core_col_counter] <= core_in_data;
            if (core_row_counter == 0 && core_col_counter == 0) begin
                cm_ar <= 0;
                cm_ac <= 0;
            end else begin
                if (int'(core_row_counter) > cm_ar) cm_ar <= int'(core_row_counter);
                if (int'(core_col_counter) > cm_ac) cm_ac <= int'(core_col_counter);
            end
        end
        if (core_can_read && core_next_matrix) begin
            cm_b[core_row_counter][core_col_counter] <= core_in_data;
            if (core_row_counter == 0 && core_col_counter == 0)
                cm_bc <= 0;
            else if (int'(core_col_counter) > cm_bc)
                cm_bc <= int'(core_col_counter);
        end
        if (core_can_cao) begin
            s = 0;
            for (int k = 0; k <= cm_ac; k++)
                s += int'(cm_a[cm_pr][k]) * int'(cm_b[k][cm_pc]);
            core_out_data <= 20'(s);
            if (cm_pc == cm_bc) begin
                cm_pc <= 0;
                cm_pr <= (cm_pr == cm_ar) ? 0 : cm_pr + 1;
            end else begin
                cm_pc <= cm_pc + 1;
            end
        end
    end

    // Host sink backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (rdy_phase % 3 == 0);
                default: m_ready = ($urandom_range(1) == 1);
            endcase
            rdy_phase++;
        end
    end

    // Monitor: scoreboard pops plus event counters.
    always @(negedge clk) begin
        if (rst) begin
            if (core_can_read) rd_cnt++;
            if (core_can_cao) cao_cnt++;
            if (core_can_read && core_can_cao) both_cnt++;
            if (err) err_cnt++;
            if (int'(dut.u_fifo.count) > OUT_DEPTH) ovf_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h, expected none", {m_last, m_data});
                end else begin
                    check("result", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_cfg(input int ar, input int ac, input int br, input int bc);
        int guard;
        cfg_valid  = 1'b1;
        cfg_a_rows = 2'(ar);
        cfg_a_cols = 2'(ac);
        cfg_b_rows = 2'(br);
        cfg_b_cols = 2'(bc);
        guard = 0;
        while (!cfg_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("cfg_accept_timeout", 32'(guard >= 200), 32'(0));
        tick();
        cfg_valid = 1'b0;
    endtask

    // Streams A then B; abort_after >= 0 stops after that many beats (no results expected).
    task automatic run_job(input int ar, input int ac, input int br, input int bc,
                           input int gap_pct, input int abort_after);
        int na, nb, idx, guard, s, v;
        logic beat_now;
        na = (ar + 1) * (ac + 1);
        nb = (br + 1) * (bc + 1);
        if (abort_after < 0) begin
            for (int i = 0; i <= ar; i++)
                for (int j = 0; j <= bc; j++) begin
                    s = 0;
                    for (int k = 0; k <= ac; k++) s += ja[i][k] * jb[k][j];
                    exp_q.push_back({(i == ar && j == bc) ? 1'b1 : 1'b0, 20'(s)});
                end
        end
        send_cfg(ar, ac, br, bc);
        idx = 0;
        guard = 0;
        while (idx < na + nb && guard < 2000) begin
            if (abort_after >= 0 && idx == abort_after) break;
            v = (idx < na) ? ja[idx / (ac + 1)][idx % (ac + 1)]
                           : jb[(idx - na) / (bc + 1)][(idx - na) % (bc + 1)];
            s_valid  = ($urandom_range(99) >= gap_pct);
            s_data   = 8'(v);
            beat_now = s_valid && s_ready;
            tick();
            if (beat_now) idx++;
            guard++;
        end
        s_valid = 1'b0;
        check("stream_timeout", 32'(guard >= 2000), 32'(0));
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (!(busy == 1'b0 && m_valid == 1'b0 && exp_q.size() == 0) && guard < 3000) begin
            tick();
            guard++;
        end
        check(name, 32'(guard >= 3000), 32'(0));
    endtask

    initial begin
        int rd0, cao0, err0, ar, ac, bc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_outs", 32'({core_rst, core_can_read, core_can_cao, core_next_matrix,
                                    core_in_data, core_row_counter, core_col_counter}), 32'(0));
        check("rst_host_outs", 32'({cfg_ready, s_ready, m_valid, m_last, err}), 32'(0));
        check("rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("init_core_rst_hi", 32'({core_rst, cfg_ready}), 32'(2'b10));
        @(negedge clk);
        check("init_core_rst_lo", 32'({core_rst, cfg_ready, busy}), 32'(3'b010));
        tick();

        // 2x2 directed job
        ja[0][0] = 1; ja[0][1] = 2; ja[1][0] = 3; ja[1][1] = 4;
        jb[0][0] = 5; jb[0][1] = 6; jb[1][0] = 7; jb[1][1] = 8;
        rdy_mode = 0;
        rd0 = rd_cnt; cao0 = cao_cnt;
        run_job(1, 1, 1, 1, 0, -1);
        wait_idle("drain_2x2");
        check("cao_cnt_2x2", 32'(cao_cnt - cao0), 32'(4));
        check("rd_cnt_2x2", 32'(rd_cnt - rd0), 32'(8));
        check("busy_after_2x2", 32'(busy), 32'(0));

        // 4x4 worst-case magnitude with 1-of-3 backpressure
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ja[i][j] = -128;
                jb[i][j] = -128;
            end
        rdy_mode = 1;
        cao0 = cao_cnt;
        run_job(3, 3, 3, 3, 0, -1);
        wait_idle("drain_4x4");
        check("cao_cnt_4x4", 32'(cao_cnt - cao0), 32'(16));

        // Illegal dims
        rdy_mode = 0;
        rd0 = rd_cnt; cao0 = cao_cnt; err0 = err_cnt;
        send_cfg(0, 2, 1, 0);
        check("illegal_err", 32'({err, s_ready, cfg_ready}), 32'(3'b101));
        tick();
        check("illegal_err_clear", 32'({err, s_ready, cfg_ready}), 32'(3'b001));
        repeat (3) tick();
        check("illegal_one_pulse", 32'(err_cnt - err0), 32'(1));
        check("illegal_no_strobes", 32'((rd_cnt - rd0) + (cao_cnt - cao0)), 32'(0));

        // 1x4 x 4x1 with stream gaps
        for (int k = 0; k < 4; k++) begin
            ja[0][k] = k + 1;
            jb[k][0] = 1;
        end
        rd0 = rd_cnt; cao0 = cao_cnt;
        run_job(0, 3, 3, 0, 50, -1);
        wait_idle("drain_1x4");
        check("rd_cnt_1x4", 32'(rd_cnt - rd0), 32'(8));
        check("cao_cnt_1x4", 32'(cao_cnt - cao0), 32'(1));

        // Reset in the middle of loading B of a 3x3 job, then the 2x2 job again
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ja[i][j] = int'($urandom_range(255)) - 128;
                jb[i][j] = int'($urandom_range(255)) - 128;
            end
        run_job(2, 2, 2, 2, 0, 13);
        check("abort_in_load_b", 32'({s_ready, busy}), 32'(2'b11));
        rst = 1'b0;
        tick();
        check("abort_reset_outs", 32'({core_can_read, s_ready, cfg_ready}), 32'(0));
        tick();
        rst = 1'b1;
        ja[0][0] = 1; ja[0][1] = 2; ja[1][0] = 3; ja[1][1] = 4;
        jb[0][0] = 5; jb[0][1] = 6; jb[1][0] = 7; jb[1][1] = 8;
        run_job(1, 1, 1, 1, 0, -1);
        wait_idle("drain_after_abort");

        // Randomized legal jobs with random gaps and backpressure
        rdy_mode = 2;
        for (int n = 0; n < 8; n++) begin
            ar = int'($urandom_range(3));
            ac = int'($urandom_range(3));
            bc = int'($urandom_range(3));
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ja[i][j] = int'($urandom_range(255)) - 128;
                    jb[i][j] = int'($urandom_range(255)) - 128;
                end
            cao0 = cao_cnt;
            run_job(ar, ac, ac, bc, int'($urandom_range(60)), -1);
            wait_idle("drain_random");
            check("cao_cnt_random", 32'(cao_cnt - cao0), 32'((ar + 1) * (bc + 1)));
        end

        check("read_cao_overlap", 32'(both_cnt), 32'(0));
        check("fifo_overflow", 32'(ovf_cnt), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
